// File: rtl/fsm_status_monitor.sv
// Status-code monitor: decodes events from the upstream FSM status code, keeps saturating
// counters, supervises consecutive errors and drives an acknowledged interrupt.
// Optional dwell timeout is enabled by defining FSM_STATUS_MON_TIMEOUT_EN.
module fsm_status_monitor #(
    parameter int CNT_W    = 8,
    parameter int ALARM_TH = 3
`ifdef FSM_STATUS_MON_TIMEOUT_EN
    ,
    parameter int TIMEOUT  = 64
`endif
) (
    input  logic             clk,
    input  logic             nrst,
    input  logic [2:0]       st_code,
    input  logic             clr,
    input  logic             irq_ack,
    output logic [CNT_W-1:0] err_cnt,
    output logic [CNT_W-1:0] seq_cnt,
    output logic             alarm,
    output logic             illegal,
    output logic             irq
`ifdef FSM_STATUS_MON_TIMEOUT_EN
    ,
    output logic             timeout
`endif
);

    localparam logic [2:0] CODE_IDLE   = 3'b000;
    localparam logic [2:0] CODE_ARMED  = 3'b001;
    localparam logic [2:0] CODE_ACTIVE = 3'b010;
    localparam logic [2:0] CODE_ERROR  = 3'b100;

    localparam logic [CNT_W-1:0] CNT_MAX    = {CNT_W{1'b1}};
    localparam logic [3:0]       CONSEC_MAX = 4'hF;
    localparam logic [4:0]       ALARM_TH_C = 5'(ALARM_TH);

    typedef enum logic [1:0] {
        ST_OK    = 2'd0,
        ST_WARN  = 2'd1,
        ST_ALARM = 2'd2
    } sup_state_e;

    sup_state_e       state_q, state_d;
    logic [2:0]       prev_code_q;
    logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
    logic [CNT_W-1:0] seq_cnt_q, seq_cnt_d;
    logic [3:0]       consec_q, consec_d;
    logic             illegal_q, illegal_d;
    logic             irq_q, irq_d;

    logic err_entry;
    logic seq_done;
    logic bad_code;
    logic consec_hit;
    logic irq_set;

`ifdef FSM_STATUS_MON_TIMEOUT_EN
    localparam int                DWELL_W   = $clog2(TIMEOUT + 1);
    localparam logic [DWELL_W-1:0] DWELL_MAX = DWELL_W'(TIMEOUT);

    logic [DWELL_W-1:0] dwell_q, dwell_d;
    logic               timeout_q, timeout_d;
`endif

    // Event decode from the previous and current code.
    always_comb begin
        err_entry  = (st_code == CODE_ERROR) && (prev_code_q != CODE_ERROR);
        seq_done   = (prev_code_q == CODE_ACTIVE) && (st_code == CODE_IDLE);
        consec_hit = ({1'b0, consec_q} + 5'd1) >= ALARM_TH_C;
        case (st_code)
            CODE_IDLE, CODE_ARMED, CODE_ACTIVE, CODE_ERROR: bad_code = 1'b0;
            default:                                        bad_code = 1'b1;
        endcase
    end

    // NOTE: every signal gets a default at the top of a combinational block so that no
    // path leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d   = state_q;
        err_cnt_d = err_cnt_q;
        seq_cnt_d = seq_cnt_q;
        consec_d  = consec_q;
        illegal_d = illegal_q;

        if (clr) begin
            state_d   = ST_OK;
            err_cnt_d = '0;
            seq_cnt_d = '0;
            consec_d  = '0;
            illegal_d = 1'b0;
        end else begin
            if (err_entry && (err_cnt_q != CNT_MAX)) err_cnt_d = err_cnt_q + 1'b1;
            if (seq_done && (seq_cnt_q != CNT_MAX)) seq_cnt_d = seq_cnt_q + 1'b1;

            if (seq_done) begin
                consec_d = '0;
            end else if (err_entry && (consec_q != CONSEC_MAX)) begin
                consec_d = consec_q + 4'd1;
            end

            if (bad_code) illegal_d = 1'b1;

            case (state_q)
                ST_OK: begin
                    if (err_entry) state_d = consec_hit ? ST_ALARM : ST_WARN;
                end
                ST_WARN: begin
                    if (err_entry && consec_hit) begin
                        state_d = ST_ALARM;
                    end else if (seq_done) begin
                        state_d = ST_OK;
                    end
                end
                ST_ALARM: state_d = ST_ALARM;
                default:  state_d = ST_OK;
            endcase
        end
    end

`ifdef FSM_STATUS_MON_TIMEOUT_EN
    // Dwell counts cycles a non-idle code is held; saturates so timeout fires once.
    always_comb begin
        dwell_d   = dwell_q;
        timeout_d = timeout_q;
        if (clr) begin
            dwell_d   = '0;
            timeout_d = 1'b0;
        end else begin
            if ((st_code != prev_code_q) || (st_code == CODE_IDLE)) begin
                dwell_d = '0;
            end else if (dwell_q != DWELL_MAX) begin
                dwell_d = dwell_q + 1'b1;
            end
            if (dwell_d == DWELL_MAX) timeout_d = 1'b1;
        end
    end
`endif

    // Set dominates acknowledge; clr never touches the interrupt.
    always_comb begin
        irq_set = ((state_d == ST_ALARM) && (state_q != ST_ALARM))
                || (illegal_d && !illegal_q);
`ifdef FSM_STATUS_MON_TIMEOUT_EN
        irq_set = irq_set || (timeout_d && !timeout_q);
`endif
        if (irq_set) begin
            irq_d = 1'b1;
        end else if (irq_ack) begin
            irq_d = 1'b0;
        end else begin
            irq_d = irq_q;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples the
    // values from before the edge, independent of statement order.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q     <= ST_OK;
            prev_code_q <= CODE_IDLE;
            err_cnt_q   <= '0;
            seq_cnt_q   <= '0;
            consec_q    <= '0;
            illegal_q   <= 1'b0;
            irq_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            prev_code_q <= st_code;
            err_cnt_q   <= err_cnt_d;
            seq_cnt_q   <= seq_cnt_d;
            consec_q    <= consec_d;
            illegal_q   <= illegal_d;
            irq_q       <= irq_d;
        end
    end

`ifdef FSM_STATUS_MON_TIMEOUT_EN
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            dwell_q   <= '0;
            timeout_q <= 1'b0;
        end else begin
            dwell_q   <= dwell_d;
            timeout_q <= timeout_d;
        end
    end

    assign timeout = timeout_q;
`endif

    assign err_cnt = err_cnt_q;
    assign seq_cnt = seq_cnt_q;
    assign alarm   = (state_q == ST_ALARM);
    assign illegal = illegal_q;
    assign irq     = irq_q;

endmodule

// File: tb/tb_fsm_status_monitor.sv
// Randomized bench for fsm_status_monitor against an event-level reference model.
module tb_fsm_status_monitor;

    localparam int CNT_W    = 3;
    localparam int ALARM_TH = 3;
    localparam int TIMEOUT  = 8;
    localparam int CNT_MAX  = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             nrst = 1'b0;
    logic [2:0]       st_code = 3'b000;
    logic             clr = 1'b0;
    logic             irq_ack = 1'b0;
    logic [CNT_W-1:0] err_cnt;
    logic [CNT_W-1:0] seq_cnt;
    logic             alarm;
    logic             illegal;
    logic             irq;
`ifdef FSM_STATUS_MON_TIMEOUT_EN
    logic             timeout;
`endif

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [2:0] m_prev;
    int         m_err, m_seq, m_consec, m_dwell;
    bit         m_alarm, m_ill, m_irq, m_tmo;

    always #5 clk = ~clk;

    fsm_status_monitor #(
        .CNT_W   (CNT_W),
        .ALARM_TH(ALARM_TH)
`ifdef FSM_STATUS_MON_TIMEOUT_EN
        ,
        .TIMEOUT (TIMEOUT)
`endif
    ) dut (
        .clk    (clk),
        .nrst   (nrst),
        .st_code(st_code),
        .clr    (clr),
        .irq_ack(irq_ack),
        .err_cnt(err_cnt),
        .seq_cnt(seq_cnt),
        .alarm  (alarm),
        .illegal(illegal),
        .irq    (irq)
`ifdef FSM_STATUS_MON_TIMEOUT_EN
        ,
        .timeout(timeout)
`endif
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0d expected %0d", tag, $time, got, exp);
        end
    endtask

    task automatic model_reset();
        m_prev   = 3'b000;
        m_err    = 0;
        m_seq    = 0;
        m_consec = 0;
        m_dwell  = 0;
        m_alarm  = 1'b0;
        m_ill    = 1'b0;
        m_irq    = 1'b0;
        m_tmo    = 1'b0;
    endtask

    task automatic model_step(input logic [2:0] code, input logic c, input logic ack);
        bit ee, sd, bad, was_alarm, was_ill, was_tmo, set;
        ee  = (code == 3'b100) && (m_prev != 3'b100);
        sd  = (m_prev == 3'b010) && (code == 3'b000);
        bad = !(code inside {3'b000, 3'b001, 3'b010, 3'b100});
        was_alarm = m_alarm;
        was_ill   = m_ill;
        was_tmo   = m_tmo;
        if (c) begin
            m_err = 0; m_seq = 0; m_consec = 0; m_dwell = 0;
            m_alarm = 1'b0; m_ill = 1'b0; m_tmo = 1'b0;
        end else begin
            if (ee && m_err < CNT_MAX) m_err++;
            if (sd && m_seq < CNT_MAX) m_seq++;
            // Alarm once this error entry makes the streak reach the threshold.
            if (ee && (m_consec + 1 >= ALARM_TH)) m_alarm = 1'b1;
            if (sd) m_consec = 0;
            else if (ee && m_consec < 15) m_consec++;
            if (bad) m_ill = 1'b1;
            if (code == m_prev && code != 3'b000) m_dwell = (m_dwell < TIMEOUT) ? m_dwell + 1 : TIMEOUT;
            else m_dwell = 0;
`ifdef FSM_STATUS_MON_TIMEOUT_EN
            if (m_dwell == TIMEOUT) m_tmo = 1'b1;
`endif
        end
        set = (m_alarm && !was_alarm) || (m_ill && !was_ill) || (m_tmo && !was_tmo);
        if (set) m_irq = 1'b1;
        else if (ack) m_irq = 1'b0;
        m_prev = code;
    endtask

    task automatic check_outputs();
        check("err_cnt", err_cnt, m_err);
        check("seq_cnt", seq_cnt, m_seq);
        check("alarm", alarm, m_alarm);
        check("illegal", illegal, m_ill);
        check("irq", irq, m_irq);
`ifdef FSM_STATUS_MON_TIMEOUT_EN
        check("timeout", timeout, m_tmo);
`endif
    endtask

    task automatic step(input logic [2:0] code, input logic c, input logic ack);
        @(negedge clk);
        st_code = code;
        clr     = c;
        irq_ack = ack;
        @(posedge clk);
        model_step(code, c, ack);
        #1;
        check_outputs();
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        #2;
        nrst = 1'b0;
        model_reset();
        #1;
        check_outputs();
        st_code = 3'b000;
        clr     = 1'b0;
        irq_ack = 1'b0;
        #1;
        nrst = 1'b1;
    endtask

    task automatic step_seq(input logic [2:0] codes[$]);
        foreach (codes[i]) step(codes[i], 1'b0, 1'b0);
    endtask

    initial begin
        logic [2:0] code;
        logic [2:0] last = 3'b000;
        int r;

        model_reset();
        #12;
        check_outputs();
        @(negedge clk);
        nrst = 1'b1;

        // Completed sequence
        step_seq('{3'b000, 3'b001, 3'b010, 3'b000});
        check("plan_seq_cnt", seq_cnt, 1);

        // Held error counts once
        step_seq('{3'b100, 3'b100, 3'b100, 3'b100, 3'b100, 3'b000});
        check("plan_err_once", err_cnt, 1);

        // Three entries raise the alarm; completion does not clear it
        step(3'b000, 1'b1, 1'b1);
        step_seq('{3'b100, 3'b000, 3'b100, 3'b000, 3'b100});
        check("plan_alarm", alarm, 1);
        step_seq('{3'b010, 3'b000});
        step(3'b000, 1'b0, 1'b1);

        // Completion between entries breaks the streak
        step(3'b000, 1'b1, 1'b0);
        step_seq('{3'b100, 3'b000, 3'b100, 3'b000, 3'b010, 3'b000,
                   3'b100, 3'b000, 3'b100, 3'b000});
        check("plan_no_alarm", alarm, 0);

        // Illegal code, acknowledge, then acknowledge colliding with alarm entry
        step(3'b000, 1'b1, 1'b1);
        step(3'b011, 1'b0, 1'b0);
        step(3'b000, 1'b0, 1'b1);
        step_seq('{3'b100, 3'b000, 3'b100, 3'b000});
        step(3'b100, 1'b0, 1'b1);
        check("plan_set_wins", irq, 1);

        // Saturation, then clr dropping a same-cycle error entry
        step(3'b000, 1'b1, 1'b1);
        for (int i = 0; i < CNT_MAX + 2; i++) step_seq('{3'b100, 3'b000});
        check("plan_saturate", err_cnt, CNT_MAX);
        step(3'b100, 1'b1, 1'b0);
        check("plan_clr_drops", err_cnt, 0);

        // Reset mid-sequence discards the pending completion
        step(3'b010, 1'b0, 1'b0);
        pulse_reset();
        step(3'b000, 1'b0, 1'b0);

        // Random traffic
        for (int n = 0; n < 3000; n++) begin
            r = $urandom_range(0, 99);
            if ($urandom_range(0, 1) == 0) code = last;
            else if (r < 25) code = 3'b000;
            else if (r < 45) code = 3'b001;
            else if (r < 65) code = 3'b010;
            else if (r < 93) code = 3'b100;
            else begin
                case ($urandom_range(0, 3))
                    0:       code = 3'b011;
                    1:       code = 3'b101;
                    2:       code = 3'b110;
                    default: code = 3'b111;
                endcase
            end
            last = code;
            step(code, $urandom_range(0, 99) < 3, $urandom_range(0, 99) < 20);
            if ($urandom_range(0, 499) == 0) pulse_reset();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fsm_status_monitor.md
Name: fsm_status_monitor

Overview:
- Downstream consumer of the 3-bit registered status code produced by the sequence-detector FSM.
- Decodes the code into events:
  - error entries
  - completed sequences
  - illegal codes
- Keeps saturating event counters and tracks consecutive errors through a small supervisor FSM.
- Raises a sticky alarm and a level interrupt with acknowledge handshake to the host side.

Parameters:
- CNT_W, 8, width of err_cnt and seq_cnt.
- ALARM_TH, 3, consecutive error entries (no intervening completion) that trigger alarm; legal range 1..15.
- TIMEOUT, 64, cycles a non-idle code may persist before timeout (only with optional feature).

Ports:
- clk  input  1  system clock, rising edge.
- nrst  input  1  asynchronous active-low reset.
- st_code  input  3  status code from the upstream FSM. Legal codes:
  - 000 idle
  - 001 armed
  - 010 active
  - 100 error
  - anything else illegal
- clr  input  1  synchronous clear of counters/alarm/flags.
- irq_ack  input  1  host acknowledge; one-cycle pulse.
- err_cnt  output  CNT_W  count of error entries, saturating.
- seq_cnt  output  CNT_W  count of completed sequences, saturating.
- alarm  output  1  sticky consecutive-error alarm.
- illegal  output  1  sticky illegal-code flag.
- irq  output  1  interrupt level, held until acknowledged.

Behaviour:
- One clock (clk); reset is asynchronous, active-low (nrst).
- Reset values:
  - err_cnt=0, seq_cnt=0, alarm=0, illegal=0, irq=0
  - prev_code=000, consec=0, supervisor state=OK
- prev_code register samples st_code every cycle. Events are decoded combinationally from (prev_code, st_code). All outputs are registered, so they reflect an event one cycle after the sampling edge.
- err_entry: st_code==100 && prev_code!=100. Holding 100 across cycles counts once.
- seq_done: prev_code==010 && st_code==000.
- bad_code: st_code not in {000,001,010,100}. Sets illegal (sticky). prev_code still updates.
- err_cnt increments on err_entry and seq_cnt on seq_done. Both saturate at 2^CNT_W-1 with no wrap.
- consec (4-bit):
  - +1 on err_entry, saturating at 15.
  - Cleared to 0 on seq_done.
- Supervisor FSM:
  - OK -> WARN on err_entry.
  - WARN -> OK on seq_done.
  - WARN -> ALARM when consec+1 >= ALARM_TH on an err_entry. With ALARM_TH=1 the transition is OK -> ALARM directly.
  - ALARM is held until clr, and seq_done does not leave it.
  - alarm = (state==ALARM).
- irq_set: entry into ALARM, or a rising edge of illegal. With the optional feature, timeout also sets irq.
  - irq goes high the cycle after irq_set.
  - irq clears the cycle after irq_ack.
  - If irq_set and irq_ack coincide, irq stays 1 (set wins).
  - irq_ack while irq=0 is ignored.
- clr:
  - Zeroes err_cnt, seq_cnt, consec, illegal and alarm; returns the FSM to OK.
  - Does not touch irq or prev_code.
  - clr has priority over events in the same cycle; those events are dropped.
- nrst asserted mid-operation returns everything to reset values immediately, with no pending event retained.

Optional Feature:
- Macro: FSM_STATUS_MON_TIMEOUT_EN.
- When defined:
  - A dwell counter (width ceil(log2(TIMEOUT+1))) counts consecutive cycles with st_code equal to prev_code and st_code != 000.
  - When it reaches TIMEOUT, a sticky output port timeout (1 bit, reset 0) is set and irq_set fires once.
  - The dwell counter resets on any code change, on code 000, and on clr; clr also clears timeout.
- When undefined: no timeout port, no dwell counter, irq sources are alarm and illegal only.

Test Plan:
- Reset then st_code sequence 000,001,010,000 -> seq_cnt=1 one cycle after the final 000; err_cnt=0, alarm=0, irq=0.
- st_code=100 held 5 cycles then 000 -> err_cnt=1 (not 5); consec=1, state WARN, alarm=0.
- Three error entries (100,000,100,000,100) with ALARM_TH=3 and no completion -> alarm=1 and irq=1 one cycle after the third 100. A following 010,000 completion leaves alarm=1.
- Two error entries, then one completion, then two error entries -> alarm stays 0; err_cnt=4.
- st_code=011 for one cycle -> illegal=1 and irq=1. Pulse irq_ack -> irq=0 next cycle while illegal stays 1. irq_ack coinciding with a new alarm entry -> irq remains 1.
- CNT_W=2 with 5 error entries -> err_cnt saturates at 3. clr asserted in the same cycle as an err_entry -> err_cnt=0, alarm=0, event not counted. nrst pulsed mid-sequence -> all outputs 0 asynchronously.
